// File: rtl/stream_upsize_buf.sv
`default_nettype none
// ============================================================================
//  Module      : stream_upsize_buf
//  Description : Packs T_DATA_RATIO narrow input beats into one wide output
//                word made of unpacked lanes, with a lane-valid keep mask.
//                Storage is one accumulator plus one output register. A group
//                closes on its last lane or on s_last_i.
//                Optional macro STREAM_UPSIZE_TIMEOUT_EN adds an idle counter
//                that flushes a partial group after TIMEOUT idle cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module stream_upsize_buf #(
  parameter int T_DATA_WIDTH = 32,
  parameter int T_DATA_RATIO = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [T_DATA_WIDTH-1:0] s_data_i,
  input  logic                    s_last_i,
  input  logic                    s_valid_i,
  output logic                    s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO],
  output logic [T_DATA_RATIO-1:0] m_keep_o,
  output logic                    m_last_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i
);

  localparam int CW = $clog2(T_DATA_RATIO + 1);  // holds a lane count 0..RATIO
  localparam int LW = $clog2(T_DATA_RATIO);      // lane index

  // Accumulator: lanes, number of filled lanes, and the pending-group flag
  logic [T_DATA_WIDTH-1:0] r_acc [T_DATA_RATIO];
  logic [CW-1:0]           r_cnt;
  logic                    r_acc_last;
  logic                    r_acc_full;

  // Output register
  logic [T_DATA_WIDTH-1:0] r_out_data [T_DATA_RATIO];
  logic [T_DATA_RATIO-1:0] r_out_keep;
  logic                    r_out_last;
  logic                    r_out_valid;

  logic                    w_accept;
  logic                    w_out_free;
  logic                    w_beat_done;
  logic                    w_flush;
  logic                    w_grp_valid;
  logic                    w_grp_last;
  logic [CW-1:0]           w_grp_cnt;
  logic [T_DATA_RATIO-1:0] w_grp_keep;
  logic [T_DATA_WIDTH-1:0] w_grp_data  [T_DATA_RATIO];
  logic [T_DATA_WIDTH-1:0] w_load_data [T_DATA_RATIO];

  // Ready depends only on local state, never on m_ready_i
  assign s_ready_o  = !rst && !r_acc_full;
  assign w_accept   = s_valid_i && s_ready_o;
  assign w_out_free = !r_out_valid || m_ready_i;
  assign w_beat_done = w_accept && (s_last_i || (r_cnt == CW'(T_DATA_RATIO - 1)));

  // Candidate group: accumulator contents merged with the beat being accepted
  always_comb begin
    w_grp_data = r_acc;
    if (w_accept) begin
      w_grp_data[r_cnt[LW-1:0]] = s_data_i;
    end
    w_grp_cnt   = w_accept ? (r_cnt + CW'(1)) : r_cnt;
    w_grp_last  = w_accept ? s_last_i : (r_acc_full && r_acc_last);
    w_grp_valid = r_acc_full || w_beat_done || w_flush;
    for (int k = 0; k < T_DATA_RATIO; k++) begin
      w_grp_keep[k]  = (CW'(k) < w_grp_cnt);
      w_load_data[k] = w_grp_keep[k] ? w_grp_data[k] : '0;
    end
  end

  // Accumulator: fill lanes, hold a completed group as pending, wrap the index
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < T_DATA_RATIO; k++) begin
        r_acc[k] <= '0;
      end
      r_cnt      <= '0;
      r_acc_last <= 1'b0;
      r_acc_full <= 1'b0;
    end else begin
      if (w_accept) begin
        r_acc <= w_grp_data;
      end
      if (w_grp_valid) begin
        if (w_out_free) begin
          r_cnt      <= '0;
          r_acc_full <= 1'b0;
          r_acc_last <= 1'b0;
        end else begin
          r_cnt      <= w_grp_cnt;
          r_acc_full <= 1'b1;
          r_acc_last <= w_grp_last;
        end
      end else if (w_accept) begin
        r_cnt <= w_grp_cnt;
      end
    end
  end

  // Output register: load a completed group when free, otherwise hold
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < T_DATA_RATIO; k++) begin
        r_out_data[k] <= '0;
      end
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (w_grp_valid && w_out_free) begin
      r_out_data  <= w_load_data;
      r_out_keep  <= w_grp_keep;
      r_out_last  <= w_grp_last;
      r_out_valid <= 1'b1;
    end else if (m_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef STREAM_UPSIZE_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] r_idle;
  logic          w_idle;

  // A partial, non-pending group with no beat arriving is idling
  assign w_idle  = (r_cnt != '0) && !r_acc_full && !w_accept;
  assign w_flush = w_idle && (r_idle == IW'(TIMEOUT - 1));

  // Idle counter: the edge that would bring it to TIMEOUT flushes instead
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle <= '0;
    end else if (!w_idle || w_flush) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + IW'(1);
    end
  end
`else
  logic [31:0] w_unused_timeout;

  assign w_flush          = 1'b0;
  assign w_unused_timeout = TIMEOUT;
`endif

  assign m_data_o  = r_out_data;
  assign m_keep_o  = r_out_keep;
  assign m_last_o  = r_out_last;
  assign m_valid_o = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_stream_upsize_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stream_upsize_buf
//  Description : Self-checking bench for stream_upsize_buf (32-bit lanes,
//                ratio 4, timeout 16). A packing model fed from observed input
//                handshakes predicts every output word.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_upsize_buf;

  localparam int DW = 32;
  localparam int RATIO = 4;
  localparam int TMO = 16;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   k;
    logic         l;
  } word_t;

  logic          clk;
  logic          rst;
  logic [DW-1:0] s_data_i;
  logic          s_last_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [DW-1:0] m_data_o [RATIO];
  logic [3:0]    m_keep_o;
  logic          m_last_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [127:0]  obs_pack;

  int n_cmp = 0;
  int n_err = 0;
  int words = 0;
  logic rand_rdy = 1'b0;

  // Model state
  word_t         exp_q[$];
  logic [DW-1:0] part[RATIO];
  int            part_n = 0;
  int            idle_n = 0;
  logic          have_hold = 1'b0;
  logic [127:0]  hold_d;
  logic [3:0]    hold_k;
  logic          hold_l;
  logic [127:0]  last_d;
  logic [3:0]    last_k;
  logic          last_l;
  logic [127:0]  first_d;
  logic          after_rst = 1'b1;

  stream_upsize_buf #(
    .T_DATA_WIDTH(DW),
    .T_DATA_RATIO(RATIO),
    .TIMEOUT     (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data_i (s_data_i),
    .s_last_i (s_last_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .m_data_o (m_data_o),
    .m_keep_o (m_keep_o),
    .m_last_o (m_last_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i)
  );

  assign obs_pack = {m_data_o[3], m_data_o[2], m_data_o[1], m_data_o[0]};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Close the model's partial group into an expected word
  task automatic model_emit(input logic l);
    word_t w;
    w.d = '0;
    for (int k = 0; k < part_n; k++) w.d[k*DW +: DW] = part[k];
    w.k = 4'((1 << part_n) - 1);
    w.l = l;
    exp_q.push_back(w);
    part_n = 0;
    idle_n = 0;
  endtask

  // Monitor at negedge: these handshakes are what the next rising edge samples
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      part_n    = 0;
      idle_n    = 0;
      have_hold = 1'b0;
      after_rst = 1'b1;
    end else begin
      if (have_hold) begin
        chk_eq("hold_valid", 128'(m_valid_o), 128'd1);
        chk_eq("hold_data", obs_pack, hold_d);
        chk_eq("hold_keep", 128'(m_keep_o), 128'(hold_k));
        chk_eq("hold_last", 128'(m_last_o), 128'(hold_l));
      end
      if (m_valid_o && m_ready_i) begin
        word_t e;
        chk_eq("keep_contig", 128'((m_keep_o & (m_keep_o + 4'd1)) == 4'd0 && m_keep_o != 4'd0), 128'd1);
        if (exp_q.size() == 0) begin
          chk_eq("unexpected_word", obs_pack, 128'd0 - 128'd1);
        end else begin
          e = exp_q.pop_front();
          chk_eq("word_data", obs_pack, e.d);
          chk_eq("word_keep", 128'(m_keep_o), 128'(e.k));
          chk_eq("word_last", 128'(m_last_o), 128'(e.l));
        end
        words++;
        last_d = obs_pack;
        last_k = m_keep_o;
        last_l = m_last_o;
        if (after_rst) begin
          first_d   = obs_pack;
          after_rst = 1'b0;
        end
      end
      have_hold = m_valid_o && !m_ready_i;
      hold_d    = obs_pack;
      hold_k    = m_keep_o;
      hold_l    = m_last_o;
      if (s_valid_i && s_ready_o) begin
        part[part_n] = s_data_i;
        part_n++;
        idle_n = 0;
        if (part_n == RATIO || s_last_i) model_emit(s_last_i);
      end else if (part_n != 0) begin
        idle_n++;
`ifdef STREAM_UPSIZE_TIMEOUT_EN
        if (idle_n == TMO) model_emit(1'b0);
`endif
      end
    end
  end

  // Random downstream backpressure
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      m_ready_i = ($urandom_range(0, 9) < 6);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one beat and return once it is accepted; waited = stall cycles
  task automatic send_beat(input logic [DW-1:0] d, input logic l, output int waited);
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = l;
    waited    = 0;
    @(negedge clk);
    while (!s_ready_o && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 200) chk_eq("send_stall", 128'(waited), 128'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int base;
    rst = 1'b1; s_valid_i = 1'b0; s_data_i = '0; s_last_i = 1'b0; m_ready_i = 1'b0;
    tick(3);
    @(negedge clk);
    chk_eq("rst_valid", 128'(m_valid_o), 128'd0);
    chk_eq("rst_keep", 128'(m_keep_o), 128'd0);
    chk_eq("rst_last", 128'(m_last_o), 128'd0);
    chk_eq("rst_data", obs_pack, 128'd0);
    chk_eq("rst_ready", 128'(s_ready_o), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_eq("ready_after_rst", 128'(s_ready_o), 128'd1);
    @(posedge clk); #1;

    // Two full words back to back, no bubbles
    m_ready_i = 1'b1;
    base = words;
    for (int i = 0; i < 8; i++) begin
      send_beat(DW'(i), (i == 7), w);
      chk_eq("bubble", 128'(w), 128'd0);
    end
    s_valid_i = 1'b0;
    tick(4);
    chk_eq("burst_words", 128'(words - base), 128'd2);
    chk_eq("burst_last_data", last_d, {32'd7, 32'd6, 32'd5, 32'd4});

    // Short packet, then single-beat packet
    send_beat(32'd10, 1'b0, w);
    send_beat(32'd11, 1'b0, w);
    send_beat(32'd12, 1'b1, w);
    s_valid_i = 1'b0;
    tick(4);
    chk_eq("short_data", last_d, {32'd0, 32'd12, 32'd11, 32'd10});
    chk_eq("short_keep", 128'(last_k), 128'(4'b0111));
    chk_eq("short_last", 128'(last_l), 128'd1);
    send_beat(32'd20, 1'b1, w);
    s_valid_i = 1'b0;
    tick(4);
    chk_eq("single_data", last_d, {32'd0, 32'd0, 32'd0, 32'd20});
    chk_eq("single_keep", 128'(last_k), 128'(4'b0001));

    // Backpressure: second group goes pending, input stalls
    m_ready_i = 1'b0;
    base = words;
    for (int i = 0; i < 8; i++) send_beat(DW'(i), (i == 7), w);
    s_valid_i = 1'b0;
    @(negedge clk);
    chk_eq("bp_ready_drop", 128'(s_ready_o), 128'd0);
    chk_eq("bp_out_data", obs_pack, {32'd3, 32'd2, 32'd1, 32'd0});
    tick(3);
    m_ready_i = 1'b1;
    tick(4);
    @(negedge clk);
    chk_eq("bp_ready_back", 128'(s_ready_o), 128'd1);
    chk_eq("bp_words", 128'(words - base), 128'd2);
    @(posedge clk); #1;

    // Reset mid-group discards the partial beats
    send_beat(32'd0, 1'b0, w);
    send_beat(32'd1, 1'b0, w);
    s_valid_i = 1'b0;
    rst = 1'b1;
    tick(2);
    @(negedge clk);
    chk_eq("midrst_ready", 128'(s_ready_o), 128'd0);
    chk_eq("midrst_valid", 128'(m_valid_o), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_eq("midrst_ready_back", 128'(s_ready_o), 128'd1);
    @(posedge clk); #1;
    for (int i = 30; i < 34; i++) send_beat(DW'(i), 1'b0, w);
    s_valid_i = 1'b0;
    tick(4);
    chk_eq("midrst_first", first_d, {32'd33, 32'd32, 32'd31, 32'd30});

    // Randomized traffic against the model
    rand_rdy = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        s_valid_i = 1'b0;
        tick($urandom_range(1, 3));
      end
      send_beat($urandom, (i == 999) || ($urandom_range(0, 4) == 0), w);
    end
    s_valid_i = 1'b0;
    rand_rdy = 1'b0;
    tick(1);
    m_ready_i = 1'b1;
    for (int i = 0; i < 200 && (exp_q.size() != 0 || m_valid_o); i++) tick(1);
    chk_eq("rand_drain", 128'(exp_q.size()), 128'd0);

    // Idle partial group: flushed only when the timeout feature is built in
    base = words;
    send_beat(32'd5, 1'b0, w);
    send_beat(32'd6, 1'b0, w);
    s_valid_i = 1'b0;
    tick(TMO + 4);
`ifdef STREAM_UPSIZE_TIMEOUT_EN
    chk_eq("tmo_words", 128'(words - base), 128'd1);
    chk_eq("tmo_data", last_d, {32'd0, 32'd0, 32'd6, 32'd5});
    chk_eq("tmo_keep", 128'(last_k), 128'(4'b0011));
    chk_eq("tmo_last", 128'(last_l), 128'd0);
`else
    chk_eq("tmo_words", 128'(words - base), 128'd0);
    chk_eq("tmo_valid", 128'(m_valid_o), 128'd0);
`endif
    send_beat(32'd7, 1'b1, w);
    s_valid_i = 1'b0;
    tick(4);
    chk_eq("final_drain", 128'(exp_q.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
